// File: rtl/m68k_bus_pkg.sv
// Shared types and encodings for the 68000 bus-cycle engine.
package m68k_bus_pkg;

  // Bus-cycle sequencer states: S1..S7 follow the 68000 half-clock states,
  // GAP separates the two word beats of a long transfer.
  typedef enum logic [3:0] {
    IDLE,
    S1,
    S2,
    S3,
    S4,
    S5,
    S6,
    S7,
    GAP
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_WORD = 2'd1;
  localparam logic [1:0] SIZE_LONG = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_BERR    = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_ILLEGAL = 2'd3;

endpackage

// File: rtl/m68k_bus_master_if.sv
// Request / status / pad-drive bundle between the Pi register file, the
// bus-cycle engine and the Amiga bus pad wiring.
interface m68k_bus_master_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int WAIT_W = 8
);
  logic                mc_clk_rising;
  logic                mc_clk_falling;
  logic                dtack_n_sync;
  logic                berr_n_sync;
  logic [DATA_W-1:0]   din_sync;

  logic                req_valid;
  logic [ADDR_W-1:0]   req_addr;
  logic [1:0]          req_size;
  logic                req_read;
  logic [2:0]          req_fc;
  logic [31:0]         req_wdata;

  logic                req_busy;
  logic                done;
  logic [1:0]          status;
  logic [31:0]         rdata;
  logic [WAIT_W-1:0]   wait_states;

  logic [ADDR_W-2:0]   abus;
  logic [DATA_W-1:0]   dbus;
  logic [2:0]          fc;
  logic                abus_oe;
  logic                dbus_oe;
  logic                fc_oe;
  logic                as_oe;
  logic                rw_oe;
  logic                uds_oe;
  logic                lds_oe;

  modport master (
    input  mc_clk_rising, mc_clk_falling, dtack_n_sync, berr_n_sync, din_sync,
    input  req_valid, req_addr, req_size, req_read, req_fc, req_wdata,
    output req_busy, done, status, rdata, wait_states,
    output abus, dbus, fc, abus_oe, dbus_oe, fc_oe, as_oe, rw_oe, uds_oe, lds_oe
  );

  modport slave (
    output mc_clk_rising, mc_clk_falling, dtack_n_sync, berr_n_sync, din_sync,
    output req_valid, req_addr, req_size, req_read, req_fc, req_wdata,
    input  req_busy, done, status, rdata, wait_states,
    input  abus, dbus, fc, abus_oe, dbus_oe, fc_oe, as_oe, rw_oe, uds_oe, lds_oe
  );
endinterface

// File: rtl/m68k_lane_steer.sv
// Byte-lane steering: strobe selection, write-data placement and read-data
// merge for byte, word and two-beat long transfers on a 16-bit bus.
module m68k_lane_steer
  import m68k_bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        a0,
  input  logic        beat,
  input  logic [31:0] wdata,
  input  logic [15:0] din,
  input  logic [31:0] rdata_cur,
  output logic        uds,
  output logic        lds,
  output logic [15:0] dout,
  output logic [31:0] rdata_nxt
);

  // Lane select, write-data mux and read merge for the current beat
  always_comb begin
    uds       = 1'b1;
    lds       = 1'b1;
    dout      = wdata[15:0];
    rdata_nxt = {16'h0000, din};
    case (size)
      SIZE_BYTE: begin
        uds       = ~a0;
        lds       = a0;
        dout      = {wdata[7:0], wdata[7:0]};
        rdata_nxt = {24'h000000, (a0 ? din[7:0] : din[15:8])};
      end
      SIZE_LONG: begin
        dout      = beat ? wdata[15:0] : wdata[31:16];
        rdata_nxt = beat ? {rdata_cur[31:16], din} : {din, rdata_cur[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/m68k_bus_master.sv
// 68000 bus-cycle engine: runs one request (byte/word/long) as one or two
// S1..S7 bus cycles, with BERR termination, DTACK timeout and wait counting.
// Only DATA_W = 16 is meaningful; a long is always split into two word beats.
module m68k_bus_master
  import m68k_bus_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 16,
  parameter int TIMEOUT_CLKS = 255,
  parameter int WAIT_W       = 8
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  m68k_bus_master_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  state_t              state_q, state_d;
  logic [ADDR_W-2:0]   abus_q, abus_d;
  logic                a0_q, a0_d;
  logic [1:0]          size_q, size_d;
  logic                read_q, read_d;
  logic [2:0]          fc_q, fc_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                beat_q, beat_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [1:0]          status_q, status_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [TW-1:0]       tcnt_q, tcnt_d, tcnt_inc;
  logic [DATA_W-1:0]   dbus_q, dbus_d;
  logic                abus_oe_q, abus_oe_d, dbus_oe_q, dbus_oe_d, fc_oe_q, fc_oe_d;
  logic                as_oe_q, as_oe_d, rw_oe_q, rw_oe_d, uds_oe_q, uds_oe_d;
  logic                lds_oe_q, lds_oe_d;

  logic                lane_uds, lane_lds;
  logic [15:0]         lane_dout;
  logic [31:0]         lane_rdata;

  m68k_lane_steer u_lane (
    .size      (size_q),
    .a0        (a0_q),
    .beat      (beat_q),
    .wdata     (wdata_q),
    .din       (bus.din_sync),
    .rdata_cur (rdata_q),
    .uds       (lane_uds),
    .lds       (lane_lds),
    .dout      (lane_dout),
    .rdata_nxt (lane_rdata)
  );

  assign tcnt_inc = tcnt_q + TW'(1);

  // State and datapath registers; async reset drops every pad enable at once
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      abus_q    <= '0;
      a0_q      <= 1'b0;
      size_q    <= '0;
      read_q    <= 1'b0;
      fc_q      <= '0;
      wdata_q   <= '0;
      beat_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= '0;
      rdata_q   <= '0;
      wait_q    <= '0;
      tcnt_q    <= '0;
      dbus_q    <= '0;
      abus_oe_q <= 1'b0;
      dbus_oe_q <= 1'b0;
      fc_oe_q   <= 1'b0;
      as_oe_q   <= 1'b0;
      rw_oe_q   <= 1'b0;
      uds_oe_q  <= 1'b0;
      lds_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      abus_q    <= abus_d;
      a0_q      <= a0_d;
      size_q    <= size_d;
      read_q    <= read_d;
      fc_q      <= fc_d;
      wdata_q   <= wdata_d;
      beat_q    <= beat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      status_q  <= status_d;
      rdata_q   <= rdata_d;
      wait_q    <= wait_d;
      tcnt_q    <= tcnt_d;
      dbus_q    <= dbus_d;
      abus_oe_q <= abus_oe_d;
      dbus_oe_q <= dbus_oe_d;
      fc_oe_q   <= fc_oe_d;
      as_oe_q   <= as_oe_d;
      rw_oe_q   <= rw_oe_d;
      uds_oe_q  <= uds_oe_d;
      lds_oe_q  <= lds_oe_d;
    end
  end

  // Next-state and next-output logic of the bus-cycle sequencer
  always_comb begin
    state_d   = state_q;
    abus_d    = abus_q;
    a0_d      = a0_q;
    size_d    = size_q;
    read_d    = read_q;
    fc_d      = fc_q;
    wdata_d   = wdata_q;
    beat_d    = beat_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    status_d  = status_q;
    rdata_d   = rdata_q;
    wait_d    = wait_q;
    tcnt_d    = tcnt_q;
    dbus_d    = dbus_q;
    abus_oe_d = abus_oe_q;
    dbus_oe_d = dbus_oe_q;
    fc_oe_d   = fc_oe_q;
    as_oe_d   = as_oe_q;
    rw_oe_d   = rw_oe_q;
    uds_oe_d  = uds_oe_q;
    lds_oe_d  = lds_oe_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          abus_d   = bus.req_addr[ADDR_W-1:1];
          a0_d     = bus.req_addr[0];
          size_d   = bus.req_size;
          read_d   = bus.req_read;
          fc_d     = bus.req_fc;
          wdata_d  = bus.req_wdata;
          beat_d   = 1'b0;
          busy_d   = 1'b1;
          status_d = ST_OK;
          wait_d   = '0;
          // Illegal requests go straight to S7 so they share its done path
          if (bus.req_size == SIZE_RSVD ||
              (bus.req_size == SIZE_LONG && bus.req_addr[0])) begin
            status_d = ST_ILLEGAL;
            state_d  = S7;
          end else begin
            abus_oe_d = 1'b1;
            fc_oe_d   = 1'b1;
            state_d   = S1;
          end
        end
      end
      S1: begin
        dbus_d = lane_dout;
        if (bus.mc_clk_rising) begin
          as_oe_d = 1'b1;
          rw_oe_d = ~read_q;
          if (read_q) begin
            uds_oe_d = lane_uds;
            lds_oe_d = lane_lds;
          end
          state_d = S2;
        end
      end
      S2: begin
        if (bus.mc_clk_falling) begin
          dbus_oe_d = ~read_q;
          state_d   = S3;
        end
      end
      S3: begin
        if (bus.mc_clk_rising) begin
          if (!read_q) begin
            uds_oe_d = lane_uds;
            lds_oe_d = lane_lds;
          end
          tcnt_d  = '0;
          state_d = S4;
        end
      end
      S4: begin
        if (bus.mc_clk_falling) begin
          if (!bus.berr_n_sync) begin
            status_d = ST_BERR;
            state_d  = S6;
          end else if (!bus.dtack_n_sync) begin
            state_d = S5;
          end else begin
            if (wait_q != '1) wait_d = wait_q + WAIT_W'(1);
            tcnt_d = tcnt_inc;
            if (tcnt_inc == TW'(TIMEOUT_CLKS)) begin
              status_d = ST_TIMEOUT;
              state_d  = S6;
            end
          end
        end
      end
      S5: begin
        if (bus.mc_clk_rising) state_d = S6;
      end
      S6: begin
        if (bus.mc_clk_falling) begin
          if (read_q && status_q == ST_OK) rdata_d = lane_rdata;
          as_oe_d  = 1'b0;
          uds_oe_d = 1'b0;
          lds_oe_d = 1'b0;
          state_d  = S7;
        end
      end
      S7: begin
        abus_oe_d = 1'b0;
        dbus_oe_d = 1'b0;
        rw_oe_d   = 1'b0;
        fc_oe_d   = 1'b0;
        if (size_q == SIZE_LONG && !beat_q && status_q == ST_OK) begin
          beat_d  = 1'b1;
          abus_d  = abus_q + (ADDR_W-1)'(1);
          state_d = GAP;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      GAP: begin
        dbus_d = lane_dout;
        if (bus.mc_clk_falling) begin
          abus_oe_d = 1'b1;
          fc_oe_d   = 1'b1;
          state_d   = S1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_busy    = busy_q;
  assign bus.done        = done_q;
  assign bus.status      = status_q;
  assign bus.rdata       = rdata_q;
  assign bus.wait_states = wait_q;
  assign bus.abus        = abus_q;
  assign bus.dbus        = dbus_q;
  assign bus.fc          = fc_q;
  assign bus.abus_oe     = abus_oe_q;
  assign bus.dbus_oe     = dbus_oe_q;
  assign bus.fc_oe       = fc_oe_q;
  assign bus.as_oe       = as_oe_q;
  assign bus.rw_oe       = rw_oe_q;
  assign bus.uds_oe      = uds_oe_q;
  assign bus.lds_oe      = lds_oe_q;

endmodule

// File: tb/tb_m68k_bus_master.sv
// Bench for m68k_bus_master: directed requests against a simple DTACK/BERR
// responder; completions and per-beat bus state checked from queues.
module tb_m68k_bus_master;
  import m68k_bus_pkg::*;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int WAIT_W = 8;
  localparam int TMO    = 4;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] rd;
    logic [7:0]  ws;
  } exp_t;

  typedef struct {
    logic [22:0] a;
    logic [15:0] d;
    logic        uds;
    logic        lds;
    logic        wr;
    logic [2:0]  f;
  } beat_t;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  m68k_bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_W(WAIT_W)) bus ();

  m68k_bus_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CLKS(TMO), .WAIT_W(WAIT_W)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  exp_t  exp_q[$];
  beat_t beat_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int beats_seen = 0;
  int beats_pushed = 0;
  logic oe_seen = 1'b0;

  // Responder configuration and falls-since-AS counter
  int          cfg_delay = 0;
  logic        cfg_nodtack = 1'b0;
  logic        cfg_berr = 1'b0;
  logic [22:0] cfg_abus0 = '0;
  logic [15:0] cfg_din0 = '0;
  logic [15:0] cfg_din1 = '0;
  int          fcnt = 0;

  always @(posedge sys_clk) begin
    if (!bus.as_oe) fcnt <= 0;
    else if (bus.mc_clk_falling) fcnt <= fcnt + 1;
  end

  // First S4 fall is the second fall after AS asserts, so fcnt==1 there
  assign bus.dtack_n_sync = !(bus.as_oe && !cfg_nodtack && fcnt >= 1 + cfg_delay);
  assign bus.berr_n_sync  = !(bus.as_oe && cfg_berr && fcnt >= 1);
  assign bus.din_sync     = (bus.abus == cfg_abus0) ? cfg_din0 : cfg_din1;

  // CLK_7M edge strobes: rise at phase 0, fall at phase 4 of 8 sys_clk
  initial begin
    int ph;
    ph = 0;
    bus.mc_clk_rising  = 1'b0;
    bus.mc_clk_falling = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      bus.mc_clk_rising  = (ph == 0);
      bus.mc_clk_falling = (ph == 4);
      ph = (ph + 1) % 8;
    end
  end

  function automatic logic [6:0] oes();
    return {bus.abus_oe, bus.dbus_oe, bus.fc_oe, bus.as_oe,
            bus.rw_oe, bus.uds_oe, bus.lds_oe};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: completion scoreboard and per-beat bus state at first S4 fall
  initial begin
    forever begin
      @(negedge sys_clk);
      if (oes() != '0) oe_seen = 1'b1;
      if (sys_rst_n) begin
        if (bus.done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            chk("done_unexpected", 32'd1, 32'd0);
          end else begin
            chk("status", {30'd0, bus.status}, {30'd0, exp_q[0].st});
            chk("rdata", bus.rdata, exp_q[0].rd);
            chk("wait_states", {24'd0, bus.wait_states}, {24'd0, exp_q[0].ws});
            chk("oes_at_done", {25'd0, oes()}, 32'd0);
            chk("busy_at_done", {31'd0, bus.req_busy}, 32'd0);
            void'(exp_q.pop_front());
          end
        end
        if (bus.as_oe && bus.mc_clk_falling && fcnt == 1) begin
          beats_seen++;
          if (beat_q.size() == 0) begin
            chk("beat_unexpected", 32'd1, 32'd0);
          end else begin
            chk("beat_abus", {9'd0, bus.abus}, {9'd0, beat_q[0].a});
            chk("beat_uds_lds", {30'd0, bus.uds_oe, bus.lds_oe},
                {30'd0, beat_q[0].uds, beat_q[0].lds});
            chk("beat_rw_dbus_oe", {30'd0, bus.rw_oe, bus.dbus_oe},
                {30'd0, beat_q[0].wr, beat_q[0].wr});
            chk("beat_addr_fc_oe", {30'd0, bus.abus_oe, bus.fc_oe}, 32'd3);
            chk("beat_fc", {29'd0, bus.fc}, {29'd0, beat_q[0].f});
            if (beat_q[0].wr) chk("beat_dbus", {16'd0, bus.dbus}, {16'd0, beat_q[0].d});
            void'(beat_q.pop_front());
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [1:0] st, input logic [31:0] rd, input logic [7:0] ws);
    exp_t e;
    e.st = st; e.rd = rd; e.ws = ws;
    exp_q.push_back(e);
  endtask

  task automatic push_beat(input logic [22:0] a, input logic [15:0] d, input logic u,
                           input logic l, input logic wr, input logic [2:0] f);
    beat_t b;
    b.a = a; b.d = d; b.uds = u; b.lds = l; b.wr = wr; b.f = f;
    beat_q.push_back(b);
    beats_pushed++;
  endtask

  task automatic cfg(input int dly, input logic nod, input logic be,
                     input logic [22:0] a0, input logic [15:0] d0, input logic [15:0] d1);
    cfg_delay = dly; cfg_nodtack = nod; cfg_berr = be;
    cfg_abus0 = a0; cfg_din0 = d0; cfg_din1 = d1;
  endtask

  task automatic issue(input logic [23:0] a, input logic [1:0] sz, input logic rd,
                       input logic [2:0] f, input logic [31:0] wd);
    @(posedge sys_clk);
    #1;
    bus.req_addr = a; bus.req_size = sz; bus.req_read = rd;
    bus.req_fc = f; bus.req_wdata = wd; bus.req_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int start, n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 2000) begin
      @(posedge sys_clk);
      n++;
    end
    chk(name, done_cnt - start, 32'd1);
  endtask

  initial begin
    int n;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_size = '0;
    bus.req_read = 1'b0; bus.req_fc = '0; bus.req_wdata = '0;

    // Reset state
    repeat (3) @(posedge sys_clk);
    #2;
    chk("rst_oes", {25'd0, oes()}, 32'd0);
    chk("rst_busy_done", {30'd0, bus.req_busy, bus.done}, 32'd0);
    chk("rst_status_wait", {22'd0, bus.status, bus.wait_states}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_abus_dbus", {bus.abus[15:0], bus.dbus}, 32'd0);
    sys_rst_n = 1'b1;

    // Word read, DTACK at first S4 fall
    cfg(0, 1'b0, 1'b0, 23'h6FF803, 16'h1234, 16'h0000);
    push_beat(23'h6FF803, 16'h0, 1'b1, 1'b1, 1'b0, 3'd5);
    push_exp(ST_OK, 32'h0000_1234, 8'd0);
    issue(24'hDFF006, SIZE_WORD, 1'b1, 3'd5, 32'h0);
    wait_done("word_read_done");

    // Long write split into two beats; a request while busy is ignored
    cfg(0, 1'b0, 1'b0, 23'h0, 16'h0, 16'h0);
    push_beat(23'h000080, 16'hDEAD, 1'b1, 1'b1, 1'b1, 3'd1);
    push_beat(23'h000081, 16'hBEEF, 1'b1, 1'b1, 1'b1, 3'd1);
    push_exp(ST_OK, 32'h0000_1234, 8'd0);
    issue(24'h000100, SIZE_LONG, 1'b0, 3'd1, 32'hDEADBEEF);
    repeat (10) @(posedge sys_clk);
    chk("busy_mid_long", {31'd0, bus.req_busy}, 32'd1);
    issue(24'h000700, SIZE_WORD, 1'b1, 3'd2, 32'h0);
    wait_done("long_write_done");

    // Byte read, odd lane
    cfg(0, 1'b0, 1'b0, 23'h5FF000, 16'hAA55, 16'h0);
    push_beat(23'h5FF000, 16'h0, 1'b0, 1'b1, 1'b0, 3'd5);
    push_exp(ST_OK, 32'h0000_0055, 8'd0);
    issue(24'hBFE001, SIZE_BYTE, 1'b1, 3'd5, 32'h0);
    wait_done("byte_read_done");

    // DTACK delayed three falls
    cfg(3, 1'b0, 1'b0, 23'h0, 16'h0, 16'h0);
    push_beat(23'h000100, 16'h5A5A, 1'b1, 1'b1, 1'b1, 3'd1);
    push_exp(ST_OK, 32'h0000_0055, 8'd3);
    issue(24'h000200, SIZE_WORD, 1'b0, 3'd1, 32'h0000_5A5A);
    wait_done("wait3_done");

    // BERR and DTACK on the same fall: BERR wins, rdata untouched
    cfg(0, 1'b0, 1'b1, 23'h000102, 16'hFFFF, 16'hFFFF);
    push_beat(23'h000102, 16'h0, 1'b1, 1'b1, 1'b0, 3'd5);
    push_exp(ST_BERR, 32'h0000_0055, 8'd0);
    issue(24'h000204, SIZE_WORD, 1'b1, 3'd5, 32'h0);
    wait_done("berr_done");

    // No DTACK: timeout after TMO falls
    cfg(0, 1'b1, 1'b0, 23'h0, 16'h0, 16'h0);
    push_beat(23'h000103, 16'h0, 1'b1, 1'b1, 1'b0, 3'd5);
    push_exp(ST_TIMEOUT, 32'h0000_0055, 8'd4);
    issue(24'h000206, SIZE_WORD, 1'b1, 3'd5, 32'h0);
    wait_done("timeout_done");

    // Long read timing out on beat 0 runs no second beat
    push_beat(23'h000104, 16'h0, 1'b1, 1'b1, 1'b0, 3'd5);
    push_exp(ST_TIMEOUT, 32'h0000_0055, 8'd4);
    issue(24'h000208, SIZE_LONG, 1'b1, 3'd5, 32'h0);
    wait_done("long_timeout_done");

    // Long read, one wait per beat, words merged hi/lo
    cfg(1, 1'b0, 1'b0, 23'h000200, 16'h1111, 16'h2222);
    push_beat(23'h000200, 16'h0, 1'b1, 1'b1, 1'b0, 3'd6);
    push_beat(23'h000201, 16'h0, 1'b1, 1'b1, 1'b0, 3'd6);
    push_exp(ST_OK, 32'h1111_2222, 8'd2);
    issue(24'h000400, SIZE_LONG, 1'b1, 3'd6, 32'h0);
    wait_done("long_read_done");

    // Byte write even lane: data replicated, UDS only
    cfg(0, 1'b0, 1'b0, 23'h0, 16'h0, 16'h0);
    push_beat(23'h000180, 16'hC3C3, 1'b1, 1'b0, 1'b1, 3'd1);
    push_exp(ST_OK, 32'h1111_2222, 8'd0);
    issue(24'h000300, SIZE_BYTE, 1'b0, 3'd1, 32'h0000_00C3);
    wait_done("byte_write_done");

    // Reserved size: done two cycles after request, no pad ever driven
    repeat (2) @(posedge sys_clk);
    oe_seen = 1'b0;
    push_exp(ST_ILLEGAL, 32'h1111_2222, 8'd0);
    issue(24'h000500, SIZE_RSVD, 1'b1, 3'd5, 32'h0);
    chk("illegal_busy", {31'd0, bus.req_busy}, 32'd1);
    @(posedge sys_clk);
    #1;
    chk("illegal_done_latency", {31'd0, bus.done}, 32'd1);
    wait_done("illegal_done");
    chk("illegal_no_oe", {31'd0, oe_seen}, 32'd0);

    // Long at odd address is illegal
    push_exp(ST_ILLEGAL, 32'h1111_2222, 8'd0);
    issue(24'h000501, SIZE_LONG, 1'b0, 3'd5, 32'h12345678);
    wait_done("long_odd_done");

    // Reset asserted in S4: pads release immediately, no done
    cfg(0, 1'b1, 1'b0, 23'h0, 16'h0, 16'h0);
    push_beat(23'h000800, 16'h0, 1'b1, 1'b1, 1'b0, 3'd5);
    issue(24'h001000, SIZE_WORD, 1'b1, 3'd5, 32'h0);
    n = 0;
    while (fcnt < 2 && n < 500) begin
      @(posedge sys_clk);
      n++;
    end
    chk("reached_s4", {31'd0, (fcnt >= 2)}, 32'd1);
    chk("s4_as_oe", {31'd0, bus.as_oe}, 32'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_oes", {25'd0, oes()}, 32'd0);
    chk("midrst_busy_done", {30'd0, bus.req_busy, bus.done}, 32'd0);
    repeat (3) @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b1;
    repeat (40) @(posedge sys_clk);

    chk("exp_queue_empty", exp_q.size(), 32'd0);
    chk("beat_queue_empty", beat_q.size(), 32'd0);
    chk("beats_seen", beats_seen, beats_pushed);
    chk("done_count", done_cnt, 32'd11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
